// File: rtl/tmr_updown_counter.sv
// Triple-modular-redundant up/down counter with continuous scrubbing, per-replica
// fault injection, sticky mismatch flags and a saturating error counter.
module tmr_updown_counter #(
    parameter int WIDTH = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    input  logic [2:0]       inj_en,
    input  logic [WIDTH-1:0] inj_mask,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic [2:0]       fault_vec,
    output logic [ERR_W-1:0] err_cnt,
    output logic             uncorr
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONE = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [WIDTH-1:0] r_q [3];
    logic [WIDTH-1:0] r_d [3];
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] n_val;
    logic [2:0]       mis;
    logic             any_mis;
    logic             wrap_d, wrap_q;
    logic [2:0]       fault_vec_d, fault_vec_q;
    logic [ERR_W-1:0] err_cnt_d, err_cnt_q;
    logic             uncorr_d, uncorr_q;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
        return (x == ERR_MAX) ? x : x + ERR_W'(1);
    endfunction

    always_comb begin
        v       = (r_q[0] & r_q[1]) | (r_q[0] & r_q[2]) | (r_q[1] & r_q[2]);
        mis     = '0;
        for (int i = 0; i < 3; i++) begin
            mis[i] = (r_q[i] != v);
        end
        any_mis = |mis;
    end

    // Next count is derived from the voted value so a single bad replica never steers it.
    always_comb begin
        n_val = v;
        if (load) begin
            n_val = load_val;
        end else if (en) begin
            n_val = up_dn ? v + ONE : v - ONE;
        end
        for (int i = 0; i < 3; i++) begin
            r_d[i] = inj_en[i] ? (n_val ^ inj_mask) : n_val;
        end
    end

    always_comb begin
        wrap_d   = !load && en && ((up_dn && (v == ALL_ONE)) || (!up_dn && (v == '0)));
        uncorr_d = (r_q[0] != r_q[1]) && (r_q[0] != r_q[2]) && (r_q[1] != r_q[2]);
        if (clr_err) begin
            fault_vec_d = mis;
            err_cnt_d   = any_mis ? ERR_W'(1) : '0;
        end else begin
            fault_vec_d = fault_vec_q | mis;
            err_cnt_d   = any_mis ? sat_inc(err_cnt_q) : err_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_q[i] <= '0;
            end
            wrap_q      <= 1'b0;
            fault_vec_q <= '0;
            err_cnt_q   <= '0;
            uncorr_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_q[i] <= r_d[i];
            end
            wrap_q      <= wrap_d;
            fault_vec_q <= fault_vec_d;
            err_cnt_q   <= err_cnt_d;
            uncorr_q    <= uncorr_d;
        end
    end

    assign q         = v;
    assign wrap      = wrap_q;
    assign fault_vec = fault_vec_q;
    assign err_cnt   = err_cnt_q;
    assign uncorr    = uncorr_q;

endmodule
